instr_mem_loader: RTL and testbench

//   Writer side of the instruction memory. Receives a program image as a byte

---
 rtl/instr_mem_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Writer side of the instruction memory. A program image arrives as a byte
// stream over a valid/ready handshake. The loader packs the bytes
// little-endian into DATA_WIDTH-bit words and writes each word to the next
// word location through a single-cycle write port. The CPU is held in reset
// while a load is in progress, and the outcome is flagged as done or error.
//
// Flow: IDLE/DONE/ERR --start--> RECV <-> WRITE --last word--> DONE
//       A zero-length load goes straight to DONE.
//       An out-of-range length goes straight to ERR.

module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [31:0]           waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  hold_cpu_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Bytes per word, and the width of the byte-within-word counter.
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Length and word counters carry one extra bit so that a full-depth load
  // (2**ADDR_WIDTH words) can be represented.
  localparam int LW = ADDR_WIDTH + 1;

  localparam logic [LW-1:0]  MAX_LEN   = LW'(1) << ADDR_WIDTH;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q,    state_d;
  logic [LW-1:0]         len_q,      len_d;
  logic [LW-1:0]         word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q,      asm_d;
  logic [31:0]           waddr_q,    waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;

  // Handshake and status outputs decode the registered state only.
  // This keeps them glitch-free and independent of the inputs.
  assign byte_ready_o = (state_q == S_RECV);
  assign we_o         = (state_q == S_WRITE);
  assign busy_o       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign hold_cpu_o   = busy_o;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);

  // The write address and data come from dedicated registers.
  // They are loaded on the entry to WRITE and keep their value afterwards;
  // only we_o qualifies them.
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

  // Next-state logic, counter logic and word assembly.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          len_d      = len_words_i;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          if (len_words_i == '0) begin
            state_d = S_DONE;
          end else if (len_words_i > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (byte_valid_i) begin
          // Place the accepted byte into its little-endian lane of the word.
          for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt_q == BCW'(k)) begin
              asm_d[8*k +: 8] = byte_data_i;
            end
          end
          if (byte_cnt_q == LAST_BYTE) begin
            // The word is complete. Capture the write beat for the next cycle.
            byte_cnt_d = '0;
            waddr_d    = 32'({word_cnt_q, 2'b00});
            wdata_d    = asm_d;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        // The write takes exactly one cycle. After it, advance to the next
        // word slot, or finish the load.
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, all with the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the assembly buffer is an ordinary flop bank, not a RAM array.
      // It therefore takes the reset, so a partial word is cleared.
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, whatever order the statements are written in.
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. Random byte images are streamed
// through the handshake. A reference model builds the expected word writes
// from the image: word i goes to byte address 4*i, and its data is the
// little-endian concatenation of image bytes i*NB .. i*NB+NB-1. The bench
// compares these expected writes with the writes observed on the memory port.

module tb_instr_mem_loader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = DW / 8;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          start_i      = 1'b0;
  logic [AW:0]   len_words_i  = '0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_data_i  = '0;
  logic          byte_ready_o;
  logic          we_o;
  logic [31:0]   waddr_o;
  logic [DW-1:0] wdata_o;
  logic          busy_o;
  logic          hold_cpu_o;
  logic          done_o;
  logic          err_o;

  instr_mem_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .len_words_i  (len_words_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .hold_cpu_o   (hold_cpu_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte image for the current load, and the writes observed on the port.
  logic [7:0]    stim[$];
  logic [31:0]   got_addr[$];
  logic [DW-1:0] got_data[$];
  int            cyc      = 0;
  int            last_acc = -10;
  int            acc_cnt  = 0;

  // Port monitor, sampled on the falling edge:
  //  - counts accepted bytes;
  //  - records each write;
  //  - checks the write-beat properties.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (byte_valid_i && byte_ready_o) begin
        acc_cnt++;
        last_acc = cyc;
      end
      if (we_o) begin
        got_addr.push_back(waddr_o);
        got_data.push_back(wdata_o);
        check("ready_in_write", byte_ready_o, 1'b0);
        check("write_latency", 64'(cyc - last_acc), 64'd1);
        check("hold_in_write", hold_cpu_o, 1'b1);
        check("busy_in_write", busy_o, 1'b1);
      end
    end
  end

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // Checks every output against zero, used while reset is asserted.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready_o, 1'b0);
    check({tag, "_we"},    we_o,         1'b0);
    check({tag, "_waddr"}, waddr_o,      32'h0);
    check({tag, "_wdata"}, wdata_o,      '0);
    check({tag, "_busy"},  busy_o,       1'b0);
    check({tag, "_hold"},  hold_cpu_o,   1'b0);
    check({tag, "_done"},  done_o,       1'b0);
    check({tag, "_err"},   err_o,        1'b0);
  endtask

  // Runs one load. It is entered and left at posedge+1.
  //  - gap_pct: percentage of cycles in which byte_valid_i is held low.
  //  - glitch_at: once this many bytes have been sent, start_i is pulsed
  //    once (-1 disables the pulse).
  //  - stop_after: the task returns after this many bytes without waiting
  //    for completion (-1 waits for completion).
  task automatic run_load(input int len, input int gap_pct, input int glitch_at,
                          input int stop_after);
    bit            valid_len = (len >= 1) && (len <= (1 << AW));
    int            nbytes    = valid_len ? len * NB : 0;
    int            budget    = (nbytes + 2) * ((gap_pct > 0) ? 20 : 2) + 20;
    int            idx       = 0;
    int            cycles    = 0;
    int            det       = -1;
    int            exp_words;
    bit            fire;
    bit            finished  = 1'b0;
    bit            glitched  = 1'b0;
    bit            prev_busy;
    logic [DW-1:0] word;

    got_addr.delete();
    got_data.delete();
    acc_cnt     = 0;
    start_i     = 1'b1;
    len_words_i = len[AW:0];
    @(posedge clk); #1;
    start_i     = 1'b0;
    len_words_i = '0;
    check("done_after_start", done_o, len == 0);
    check("err_after_start", err_o, len > (1 << AW));
    check("busy_after_start", busy_o, valid_len);
    prev_busy = busy_o;

    while (!finished && cycles < budget && !(stop_after >= 0 && idx >= stop_after)) begin
      if (idx < nbytes && $urandom_range(99) >= gap_pct) begin
        byte_valid_i = 1'b1;
        byte_data_i  = stim[idx];
      end else begin
        // After the whole image has been sent, spare bytes remain offered.
        // They must never be consumed.
        byte_valid_i = (idx >= nbytes);
        byte_data_i  = 8'($urandom);
      end
      if (glitch_at >= 0 && idx >= glitch_at && !glitched) begin
        glitched    = 1'b1;
        start_i     = 1'b1;
        len_words_i = (AW + 1)'(5);
      end
      @(negedge clk);
      fire = byte_valid_i && byte_ready_o;
      if (done_o || err_o) begin
        finished = 1'b1;
        det      = cycles;
        if (done_o && valid_len) begin
          check("busy_falls_with_done", busy_o, 1'b0);
          check("busy_before_done", prev_busy, 1'b1);
        end
      end
      prev_busy = busy_o;
      @(posedge clk); #1;
      start_i     = 1'b0;
      len_words_i = '0;
      if (fire) idx++;
      cycles++;
    end
    byte_valid_i = 1'b0;

    if (stop_after < 0) begin
      check("finished", finished, 1'b1);
      if (valid_len && gap_pct == 0) check("throughput", 64'(det), 64'(len * (NB + 1)));
      if (!valid_len) check("flag_latency", 64'(det), 64'd0);
      check("done_flag", done_o, len <= (1 << AW));
      check("err_flag", err_o, len > (1 << AW));
      check("accepted_bytes", 64'(acc_cnt), 64'(nbytes));
      exp_words = valid_len ? len : 0;
    end else begin
      check("accepted_bytes", 64'(acc_cnt), 64'(stop_after));
      exp_words = stop_after / NB;
    end

    check("write_count", 64'(got_addr.size()), 64'(exp_words));
    for (int w = 0; w < exp_words && w < got_addr.size(); w++) begin
      word = '0;
      for (int k = 0; k < NB; k++) word[8*k +: 8] = stim[w*NB + k];
      check("waddr", got_addr[w], 64'(w * 4));
      check("wdata", got_data[w], word);
    end
  endtask

  // Offers bytes while the loader is not receiving. Checks that no byte is
  // taken and that the status flags stay as they are.
  task automatic idle_offer(input int n, input bit exp_done, input bit exp_err);
    for (int i = 0; i < n; i++) begin
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
      @(negedge clk);
      check("idle_ready", byte_ready_o, 1'b0);
      check("idle_done", done_o, exp_done);
      check("idle_err", err_o, exp_err);
      check("idle_busy", busy_o, 1'b0);
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
  endtask

  initial begin
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready_after_reset", byte_ready_o, 1'b0);

    // Directed two-word image at full rate.
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2, 0, -1, -1);
    if (got_addr.size() == 2) begin
      check("dir_addr0", got_addr[0], 32'h0);
      check("dir_data0", got_data[0], 32'h12345678);
      check("dir_addr1", got_addr[1], 32'h4);
      check("dir_data1", got_data[1], 32'hDEADBEEF);
    end
    idle_offer(3, 1'b1, 1'b0);

    // Single-word loads with random gaps in byte_valid_i.
    for (int r = 0; r < 3; r++) begin
      fill_random(NB);
      run_load(1, 40 + r * 10, -1, -1);
    end

    // Zero length: the loader goes to DONE at once, with no write.
    run_load(0, 0, -1, -1);

    // Out-of-range lengths: the loader goes to ERR, with no write and
    // no byte taken.
    run_load((1 << AW) + 1, 0, -1, -1);
    idle_offer(4, 1'b0, 1'b1);
    run_load(2047, 0, -1, -1);

    // Random short loads; some of them start from ERR or DONE.
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 6);
      fill_random(len * NB);
      run_load(len, $urandom_range(0, 60), -1, -1);
    end

    // Full-depth load, with a start pulse part-way through that must be
    // ignored.
    fill_random((1 << AW) * NB);
    run_load(1 << AW, 0, 2001, -1);
    if (got_addr.size() > 0) check("last_waddr", got_addr[got_addr.size() - 1], 32'hFFC);

    // Reset is asserted mid-cycle after two bytes of word 1. The partial
    // word must be dropped without a write.
    fill_random(2 * NB);
    run_load(2, 0, -1, NB + 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_offer(3, 1'b0, 1'b0);
    check("no_write_after_rst", 64'(got_addr.size()), 64'd1);
    fill_random(NB);
    run_load(1, 30, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case a wait is ever left unbounded.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
